pla_equiv_checker: RTL and testbench

- Sequential stimulus/response end for the 27-input, single-output logic cones in the benchmark set.
- Drives an incrementing input vector into two instances of the same cone (original and optimised netlist).
- Samples both y outputs after a fixed latency and counts disagreements and output ones.
- Records the first failing vector; a run is one start/done transaction.

---
 rtl/pla_equiv_checker.sv | 191 +++++++++++++++++++
 tb/tb_pla_equiv_checker.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_equiv_checker.sv
// pla_equiv_checker
//
// Stimulus/response end for comparing two copies of a single-output logic cone
// (original and optimised netlist). After a start, it drives an incrementing
// input vector into both cones. It samples both cone outputs a fixed number of
// cycles later and counts disagreements and output ones. It also records the
// first vector on which the two cones disagree.
//
// Parameters:
//   N_IN   width of the input vector driven to the cones (1..32)
//   LAT    cycles from a vec_out change to y_ref/y_dut being sampled (1..8)
//   CNT_W  width of the vector-count and result counters
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   start            begin a run; only accepted while idle
//   seed             first vector of the run, sampled on an accepted start
//   num_vec          number of vectors to apply, sampled on an accepted start
//   vec_out          vector driven to both cones
//   y_ref            output of the original cone
//   y_dut            output of the optimised cone
//   busy             high from the accepted start until done
//   done             one-cycle pulse at the end of a run
//   mismatch_cnt     vectors with y_ref != y_dut (saturating)
//   ones_cnt         vectors with y_ref == 1 (saturating)
//   first_fail_valid a mismatch has been recorded in this run
//   first_fail_vec   vector that produced the first mismatch

module pla_equiv_checker #(
  parameter int N_IN  = 27,
  parameter int LAT   = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_IN-1:0]  seed,
  input  logic [CNT_W-1:0] num_vec,
  output logic [N_IN-1:0]  vec_out,
  input  logic             y_ref,
  input  logic             y_dut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rem;
  logic [LAT-1:0]   pipe_valid;
  logic [N_IN-1:0]  pipe_vec [LAT];

  logic accept;
  logic issue;
  logic sample;
  logic older_stages_empty;

  assign accept = (state == IDLE) && start;
  assign issue  = (state == RUN);
  assign sample = pipe_valid[LAT-1];

  // Only the oldest stage can still be occupied, and it is sampled on this
  // edge. So the pipeline will be empty after the edge, and DRAIN may finish.
  // With LAT=1 this is always true, which gives the single drain cycle.
  assign older_stages_empty = (pipe_valid & ~(LAT'(1) << (LAT - 1))) == '0;

  // State register: the FSM returns to IDLE on reset, which aborts any run
  // without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A zero-length run skips RUN and goes straight to DRAIN,
  // so that the done pulse timing still follows the normal path.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_vec == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (rem <= CNT_W'(1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (older_stages_empty) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the state alone. busy therefore falls in
  // the same cycle that done rises.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Vector generator. It loads the seed and the run length on an accepted
  // start. It then steps once per issue and wraps naturally at N_IN bits.
  // vec_out keeps its last value after the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out <= '0;
      rem     <= '0;
    end else if (accept) begin
      vec_out <= seed;
      rem     <= num_vec;
    end else if (issue) begin
      vec_out <= vec_out + N_IN'(1);
      rem     <= rem - CNT_W'(1);
    end
  end

  // Issue pipeline. Each issued vector travels LAT stages alongside its valid
  // bit. When it reaches the last stage, the cone outputs for that vector are
  // present on y_ref/y_dut.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_vec[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= issue;
      pipe_vec[0]   <= vec_out;
      for (int i = 1; i < LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_vec[i]   <= pipe_vec[i-1];
      end
    end
  end

  // Result accumulation. The results are cleared on an accepted start and are
  // touched only on sampling edges. Both counters stick at all-ones. Only the
  // first mismatching vector of a run is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_cnt     <= '0;
      ones_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (accept) begin
      mismatch_cnt     <= '0;
      ones_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (sample) begin
      if (y_ref != y_dut) begin
        if (mismatch_cnt != '1) begin
          mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_vec   <= pipe_vec[LAT-1];
        end
      end
      if (y_ref) begin
        if (ones_cnt != '1) begin
          ones_cnt <= ones_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pla_equiv_checker.sv
// tb_pla_equiv_checker
//
// Self-checking bench for pla_equiv_checker. It instantiates two checkers:
// dut1 with LAT=1 and dut3 with LAT=3. Each checker drives a small registered
// cone model whose output is vec[0]&vec[1] of a delayed copy of vec_out.
// Fault injection and a short-delay variant make the two cone outputs
// disagree. Expected run results are pushed to a scoreboard before each start
// and popped when done is seen.

module tb_pla_equiv_checker;

  localparam int N_IN  = 27;
  localparam int CNT_W = 32;

  typedef struct {
    logic [CNT_W-1:0] mism;
    logic [CNT_W-1:0] ones;
    logic             ffv;
    logic [N_IN-1:0]  ffvec;
    int               cycles;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start1, start3;
  logic [N_IN-1:0]  seed;
  logic [CNT_W-1:0] num_vec;

  logic [N_IN-1:0]  vec1, ffvec1, vec3, ffvec3;
  logic             yr1, yd1, busy1, done1, ffv1;
  logic             yr3, yd3, busy3, done3, ffv3;
  logic [CNT_W-1:0] mc1, oc1, mc3, oc3;

  logic             inject;
  logic             dly2;
  logic [N_IN-1:0]  r1a, r3a, r3b, r3c;

  exp_t             sb[$];
  logic [N_IN-1:0]  trace[$];
  int               total  = 0;
  int               passed = 0;

  always #5 clk = ~clk;

  pla_equiv_checker #(.N_IN(N_IN), .LAT(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .seed(seed), .num_vec(num_vec),
    .vec_out(vec1), .y_ref(yr1), .y_dut(yd1), .busy(busy1), .done(done1),
    .mismatch_cnt(mc1), .ones_cnt(oc1), .first_fail_valid(ffv1),
    .first_fail_vec(ffvec1)
  );

  pla_equiv_checker #(.N_IN(N_IN), .LAT(3), .CNT_W(CNT_W)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .seed(seed), .num_vec(num_vec),
    .vec_out(vec3), .y_ref(yr3), .y_dut(yd3), .busy(busy3), .done(done3),
    .mismatch_cnt(mc3), .ones_cnt(oc3), .first_fail_valid(ffv3),
    .first_fail_vec(ffvec3)
  );

  function automatic logic cone(input logic [N_IN-1:0] v);
    return v[0] & v[1];
  endfunction

  // Registered cone models: a delay of one register for dut1, and three
  // registers for dut3 (or two when dly2 is set).
  always @(posedge clk) begin
    r1a <= vec1;
    r3a <= vec3;
    r3b <= r3a;
    r3c <= r3b;
  end

  assign yr1 = cone(r1a);
  assign yd1 = cone(r1a) ^ (inject && (r1a == 27'd5 || r1a == 27'd9));
  assign yr3 = cone(r3c);
  assign yd3 = dly2 ? cone(r3b) : cone(r3c);

  // Reference model of one run at the vector level.
  task automatic push_expected(input bit sel, input logic [N_IN-1:0] s,
                               input logic [CNT_W-1:0] n);
    exp_t e;
    logic [N_IN-1:0] v, vd;
    logic r, d;
    int lat;
    lat = sel ? 3 : 1;
    e.mism = '0; e.ones = '0; e.ffv = 1'b0; e.ffvec = '0;
    for (longint i = 0; i < longint'(n); i++) begin
      v = s + N_IN'(i);
      if (sel && dly2) vd = s + N_IN'((i + 1 < longint'(n)) ? i + 1 : longint'(n));
      else             vd = v;
      r = cone(v);
      d = sel ? cone(vd) : (cone(v) ^ (inject && (v == 27'd5 || v == 27'd9)));
      if (r != d) begin
        e.mism++;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffvec = v;
        end
      end
      if (r) e.ones++;
    end
    e.cycles = (n == '0) ? 2 : int'(n) + lat + 1;
    sb.push_back(e);
  endtask

  // Starts one run and waits, with a bound, for done. It then pops the
  // scoreboard and compares the run results. With hold set, start stays high
  // and seed/num_vec change during the run.
  task automatic applyStimulus(input bit sel, input logic [N_IN-1:0] s,
                               input logic [CNT_W-1:0] n, input bit hold);
    exp_t e;
    int cycles;
    @(negedge clk);
    seed = s;
    num_vec = n;
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    trace.delete();
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    if (hold) begin
      seed = s + 27'd100;
      num_vec = n + 32'd7;
    end else begin
      start1 = 1'b0;
      start3 = 1'b0;
    end
    trace.push_back(sel ? vec3 : vec1);
    while (!(sel ? done3 : done1) && cycles < 300) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      trace.push_back(sel ? vec3 : vec1);
    end
    start1 = 1'b0;
    start3 = 1'b0;
    e = sb.pop_front();
    total++;
    if (cycles !== e.cycles) $display("[TB] FAIL done_latency dut%0d: got %0d cycles, expected %0d", sel ? 3 : 1, cycles, e.cycles);
    else passed++;
    total++;
    if ((sel ? mc3 : mc1) !== e.mism) $display("[TB] FAIL mismatch_cnt dut%0d: got %0d, expected %0d", sel ? 3 : 1, sel ? mc3 : mc1, e.mism);
    else passed++;
    total++;
    if ((sel ? oc3 : oc1) !== e.ones) $display("[TB] FAIL ones_cnt dut%0d: got %0d, expected %0d", sel ? 3 : 1, sel ? oc3 : oc1, e.ones);
    else passed++;
    total++;
    if ((sel ? ffv3 : ffv1) !== e.ffv) $display("[TB] FAIL first_fail_valid dut%0d: got %0b, expected %0b", sel ? 3 : 1, sel ? ffv3 : ffv1, e.ffv);
    else passed++;
    total++;
    if ((sel ? ffvec3 : ffvec1) !== e.ffvec) $display("[TB] FAIL first_fail_vec dut%0d: got %0h, expected %0h", sel ? 3 : 1, sel ? ffvec3 : ffvec1, e.ffvec);
    else passed++;
    total++;
    if ((sel ? busy3 : busy1) !== 1'b0) $display("[TB] FAIL busy_at_done dut%0d: got %0b, expected 0", sel ? 3 : 1, sel ? busy3 : busy1);
    else passed++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({vec1, busy1, done1, mc1, oc1, ffv1, ffvec1} !== '0) $display("[TB] FAIL reset_state dut1: got %0h, expected 0", {vec1, busy1, done1, mc1, oc1, ffv1, ffvec1});
    else passed++;
    total++;
    if ({vec3, busy3, done3, mc3, oc3, ffv3, ffvec3} !== '0) $display("[TB] FAIL reset_state dut3: got %0h, expected 0", {vec3, busy3, done3, mc3, oc3, ffv3, ffvec3});
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_reset_midrun;
    bit seen_done;
    seen_done = 1'b0;
    @(negedge clk);
    seed = '0;
    num_vec = 32'd100;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy1, vec1} !== {1'b1, 27'd10}) $display("[TB] FAIL midrun_state: got busy=%0b vec=%0h, expected busy=1 vec=a", busy1, vec1);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({vec1, busy1, done1, mc1, oc1, ffv1, ffvec1} !== '0) $display("[TB] FAIL async_reset: got %0h, expected 0", {vec1, busy1, done1, mc1, oc1, ffv1, ffvec1});
    else passed++;
    repeat (2) begin
      @(negedge clk);
      if (done1) seen_done = 1'b1;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done1 || busy1) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) $display("[TB] FAIL reset_abort: got done/busy activity=%0b, expected 0", seen_done);
    else passed++;
  endtask

  task automatic test_equivalent;
    inject = 1'b0;
    push_expected(1'b0, '0, 32'd16);
    applyStimulus(1'b0, '0, 32'd16, 1'b0);
  endtask

  task automatic test_injected;
    inject = 1'b1;
    push_expected(1'b0, '0, 32'd16);
    applyStimulus(1'b0, '0, 32'd16, 1'b0);
  endtask

  task automatic test_zero_vectors;
    push_expected(1'b0, 27'd3, '0);
    applyStimulus(1'b0, 27'd3, '0, 1'b0);
  endtask

  task automatic test_wrap;
    logic [N_IN-1:0] exp_vecs[$];
    logic [N_IN-1:0] ev;
    inject = 1'b0;
    exp_vecs = '{27'h7FFFFFE, 27'h7FFFFFF, 27'h0000000, 27'h0000001};
    push_expected(1'b0, 27'h7FFFFFE, 32'd4);
    applyStimulus(1'b0, 27'h7FFFFFE, 32'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ev = exp_vecs.pop_front();
      total++;
      if (trace.size() <= k || trace[k] !== ev) $display("[TB] FAIL wrap_vec[%0d]: got %0h, expected %0h", k, (trace.size() > k) ? trace[k] : 27'h0, ev);
      else passed++;
    end
  endtask

  task automatic test_start_held;
    inject = 1'b1;
    push_expected(1'b0, '0, 32'd16);
    applyStimulus(1'b0, '0, 32'd16, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if ({busy1, done1} !== 2'b00) $display("[TB] FAIL no_second_run: got busy=%0b done=%0b, expected 0 0", busy1, done1);
    else passed++;
  endtask

  task automatic test_latency;
    dly2 = 1'b0;
    push_expected(1'b1, '0, 32'd8);
    applyStimulus(1'b1, '0, 32'd8, 1'b0);
  endtask

  task automatic test_latency_short_model;
    dly2 = 1'b1;
    push_expected(1'b1, '0, 32'd8);
    applyStimulus(1'b1, '0, 32'd8, 1'b0);
    dly2 = 1'b0;
  endtask

  task automatic test_back_to_back;
    inject = 1'b1;
    push_expected(1'b0, 27'd1, 32'd6);
    applyStimulus(1'b0, 27'd1, 32'd6, 1'b0);
    push_expected(1'b0, 27'd7, 32'd5);
    applyStimulus(1'b0, 27'd7, 32'd5, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    seed = '0;
    num_vec = '0;
    inject = 1'b0;
    dly2 = 1'b0;
    test_reset();
    test_reset_midrun();
    test_equivalent();
    test_injected();
    test_zero_vectors();
    test_wrap();
    test_start_held();
    test_latency();
    test_latency_short_model();
    test_back_to_back();
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
